alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 100 ++++++++++
 tb/tb_alu_result_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// ============================================================================
//  Module      : alu_result_fifo
//  Description : First-word fall-through FIFO for ALU results and their
//                exception/overflow/underflow flags, with sticky flag
//                accumulation and a running count of accepted results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_exception,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2:0]               sticky_flags,
    input  logic                     sticky_clear,
    output logic [15:0]              accepted
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = DEPTH[c_AW:0];

    logic [WIDTH+2:0]  r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [2:0]        r_sticky;
    logic [15:0]       r_accepted;
    logic              r_live;

    logic              w_enq;
    logic              w_deq;
    logic [2:0]        w_in_flags;

    assign w_in_flags = {in_exception, in_overflow, in_underflow};

    // Readiness comes only from registered state; r_live keeps in_ready low
    // through reset until the first edge after release.
    assign in_ready  = r_live && (r_count < c_FULL);
    assign out_valid = (r_count != '0);
    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sticky   <= 3'b000;
            r_accepted <= 16'h0000;
        end else begin
            r_live <= 1'b1;
            if (w_enq) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_accepted <= r_accepted + 16'h0001;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
            // Flags enqueued on a clearing edge survive the clear.
            if (w_enq) begin
                r_sticky <= (sticky_clear ? 3'b000 : r_sticky) | w_in_flags;
            end else if (sticky_clear) begin
                r_sticky <= 3'b000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {w_in_flags, in_result};
        end
    end

    assign {out_flags, out_result} = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign sticky_flags = r_sticky;
    assign accepted     = r_accepted;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
// ============================================================================
//  Module      : tb_alu_result_fifo
//  Description : Directed scoreboard bench for alu_result_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_result;
    logic              in_exception;
    logic              in_overflow;
    logic              in_underflow;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [2:0]        out_flags;
    logic [3:0]        count;
    logic [2:0]        sticky_flags;
    logic              sticky_clear;
    logic [15:0]       accepted;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH+2:0] sb [$];

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_exception (in_exception),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count),
        .sticky_flags (sticky_flags),
        .sticky_clear (sticky_clear),
        .accepted     (accepted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change just after a rising edge, so the handshake
    // seen at the falling edge is the one the next rising edge will take.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {1'b0, out_flags, out_result[27:0]}, 32'hFFFF_FFFF);
            end else begin
                logic [WIDTH+2:0] e;
                e = sb.pop_front();
                chk("out_result", out_result, e[WIDTH-1:0]);
                chk("out_flags", {29'd0, out_flags}, {29'd0, e[WIDTH+2:WIDTH]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record an expected entry whenever the upcoming edge will enqueue.
    task automatic go();
        if (in_valid && in_ready)
            sb.push_back({in_exception, in_overflow, in_underflow, in_result});
        step();
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic [2:0] f);
        in_valid = v;
        in_result = d;
        {in_exception, in_overflow, in_underflow} = f;
    endtask

    task automatic drain(input string name);
        int i;
        set_in(1'b0, 32'd0, 3'b000);
        out_ready = 1'b1;
        for (i = 0; i < 40 && count != 0; i++) go();
        out_ready = 1'b0;
        chk({name, "_drain_count"}, {28'd0, count}, 32'd0);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #2;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        set_in(1'b0, 32'd0, 3'b000);
        out_ready = 1'b0;
        sticky_clear = 1'b0;

        // Reset state, then in_ready rises on the first edge after release.
        #2;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_accepted", {16'd0, accepted}, 32'd0);
        chk("rst_sticky", {29'd0, sticky_flags}, 32'd0);
        #10;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
        step();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Single pass.
        set_in(1'b1, 32'h4040_0000, 3'b000);
        go();
        set_in(1'b0, 32'd0, 3'b000);
        chk("single_out_valid", {31'd0, out_valid}, 32'd1);
        chk("single_count", {28'd0, count}, 32'd1);
        chk("single_head", out_result, 32'h4040_0000);
        out_ready = 1'b1;
        go();
        out_ready = 1'b0;
        chk("single_count_after", {28'd0, count}, 32'd0);
        chk("single_valid_after", {31'd0, out_valid}, 32'd0);

        // Fill and drain with in_valid held through the full period.
        do_reset();
        k = 0;
        for (int c = 0; c < 11; c++) begin
            set_in(1'b1, k, 3'(k % 8));
            if (in_ready) k++;
            go();
        end
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_count", {28'd0, count}, 32'd8);
        chk("fill_accepted", {16'd0, accepted}, 32'd8);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (k < 10 || count != 0); c++) begin
            set_in(k < 10, k, 3'(k % 8));
            if (in_valid && in_ready) k++;
            go();
        end
        set_in(1'b0, 32'd0, 3'b000);
        out_ready = 1'b0;
        chk("fill_accepted_end", {16'd0, accepted}, 32'd10);
        chk("fill_sb_empty", sb.size(), 32'd0);

        // Simultaneous enqueue/dequeue at occupancy 3.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 32'h100 + c, 3'b000);
            go();
        end
        chk("sim_count_start", {28'd0, count}, 32'd3);
        out_ready = 1'b1;
        for (int c = 3; c < 23; c++) begin
            set_in(1'b1, 32'h100 + c, 3'(c % 8));
            go();
            chk("sim_count_hold", {28'd0, count}, 32'd3);
        end
        drain("sim");

        // Sticky flags.
        do_reset();
        set_in(1'b1, 32'h1, 3'b010); go();
        set_in(1'b1, 32'h2, 3'b001); go();
        set_in(1'b0, 32'h0, 3'b000);
        chk("sticky_or", {29'd0, sticky_flags}, 32'd3);
        sticky_clear = 1'b1;
        set_in(1'b1, 32'h3, 3'b100); go();
        set_in(1'b0, 32'h0, 3'b000);
        chk("sticky_clear_set", {29'd0, sticky_flags}, 32'd4);
        go();
        sticky_clear = 1'b0;
        chk("sticky_clear_only", {29'd0, sticky_flags}, 32'd0);
        drain("sticky");

        // Asynchronous reset with five entries stored.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_in(1'b1, 32'h500 + c, 3'b111);
            go();
        end
        set_in(1'b0, 32'd0, 3'b000);
        chk("mid_count_before", {28'd0, count}, 32'd5);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_count", {28'd0, count}, 32'd0);
        chk("mid_accepted", {16'd0, accepted}, 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
        set_in(1'b1, 32'h0000_ABCD, 3'b001); go();
        drain("mid");

        // accepted wraps after 65536 enqueues.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 65535; c++) begin
            set_in(1'b1, c, 3'b000);
            go();
        end
        chk("wrap_ffff", {16'd0, accepted}, 32'h0000_FFFF);
        set_in(1'b1, 32'hFFFF, 3'b000);
        go();
        chk("wrap_zero", {16'd0, accepted}, 32'd0);
        drain("wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
